// File: rtl/mul_seq.sv
// mul_seq: multiply sequencer for a cascaded Am2901 slice array.
//
// On start it loads the multiplier into Q, clears the accumulator, then runs
// NBITS shift-and-add steps (RAMQD) that build accumulator:Q = mcand x mult.
// It then presents the product on the slice Y bus: low half (Q) first, then
// the high half (accumulator). While busy is high this block owns the slice
// controls.
//
// Build option:
//   MULSEQ_SIGNED_EN  two's-complement multiply. Every step shifts in the true
//                     sign (F3^OVR), and the final step subtracts the
//                     multiplicand when the multiplier sign bit is set.
//                     Left undefined, the sequencer multiplies unsigned only.
module mul_seq #(
  parameter int NBITS = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] acc_addr,
  input  logic [3:0] mcand_addr,
  input  logic       q_lsb,
  output logic [8:0] I,
  output logic [3:0] Aadd,
  output logic [3:0] Badd,
  output logic       C0,
  output logic       d_sel,
  output logic [1:0] ram_msb_sel,
  output logic       busy,
  output logic       y_valid,
  output logic       y_hi,
  output logic       done
);

  // Step counter is wide enough for NBITS itself.
  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Am2901 destination control, I[8:6]
  localparam logic [2:0] DST_QREG  = 3'd0;  // F -> Q
  localparam logic [2:0] DST_NOP   = 3'd1;  // no write, Y = F
  localparam logic [2:0] DST_RAMF  = 3'd3;  // F -> RAM[B]
  localparam logic [2:0] DST_RAMQD = 3'd4;  // F/2 -> RAM[B], Q/2 -> Q

  // Am2901 ALU function, I[5:3]
  localparam logic [2:0] FN_ADD  = 3'd0;    // R + S
  localparam logic [2:0] FN_OR   = 3'd3;    // R | S
  localparam logic [2:0] FN_AND  = 3'd4;    // R & S
`ifdef MULSEQ_SIGNED_EN
  localparam logic [2:0] FN_SUBR = 3'd1;    // S - R (with C0 = 1)
`endif

  // Am2901 source operands, I[2:0]
  localparam logic [2:0] SRC_AB = 3'd1;     // R = A, S = B
  localparam logic [2:0] SRC_ZQ = 3'd2;     // R = 0, S = Q
  localparam logic [2:0] SRC_ZB = 3'd3;     // R = 0, S = B
  localparam logic [2:0] SRC_DZ = 3'd7;     // R = D, S = 0

  // RAM3 shift-in source used during the step phase.
  // Unsigned: carry out (C4) extends the sum; signed: F3^OVR is the true sign.
`ifdef MULSEQ_SIGNED_EN
  localparam logic [1:0] STEP_MSB_SEL = 2'd2;
`else
  localparam logic [1:0] STEP_MSB_SEL = 2'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADQ = 3'd1,
    S_CLEAR = 3'd2,
    S_STEP  = 3'd3,
    S_RDLO  = 3'd4,
    S_RDHI  = 3'd5
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [3:0]       acc_reg;
  logic [3:0]       mcand_reg;
  logic             last_step;

  logic [2:0]       dst;
  logic [2:0]       fn;
  logic [2:0]       src;

  // Counter reaching zero while stepping marks the final shift-and-add.
  assign last_step = (count_reg == '0);

  // State and step-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Address latch: captured only when a start is accepted, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= 4'd0;
      mcand_reg <= 4'd0;
    end else if (state_reg == S_IDLE && start) begin
      acc_reg   <= acc_addr;
      mcand_reg <= mcand_addr;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOADQ;
      end
      S_LOADQ: begin
        state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next = S_STEP;
        count_next = CNT_LOAD;
      end
      S_STEP: begin
        if (last_step) state_next = S_RDLO;
        else           count_next = count_reg - CNT_ONE;
      end
      S_RDLO: begin
        state_next = S_RDHI;
      end
      S_RDHI: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Slice control decode. Everything depends only on the state register,
  // except the step-phase source (and sign correction), which follows the
  // multiplier bit q_lsb in the same cycle.
  always_comb begin
    dst         = DST_NOP;
    fn          = FN_OR;
    src         = SRC_ZB;
    C0          = 1'b0;
    d_sel       = 1'b0;
    ram_msb_sel = 2'd0;
    y_valid     = 1'b0;
    y_hi        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Harmless NOP: no register or RAM write.
      end
      S_LOADQ: begin
        // Q <- D + 0, multiplier comes from the top-level D mux.
        dst   = DST_QREG;
        fn    = FN_ADD;
        src   = SRC_DZ;
        d_sel = 1'b1;
      end
      S_CLEAR: begin
        // accumulator <- 0 AND B
        dst = DST_RAMF;
        fn  = FN_AND;
        src = SRC_ZB;
      end
      S_STEP: begin
        // Add the multiplicand only when the current multiplier bit is set,
        // then shift accumulator:Q right by one.
        dst         = DST_RAMQD;
        fn          = FN_ADD;
        src         = q_lsb ? SRC_AB : SRC_ZB;
        ram_msb_sel = STEP_MSB_SEL;
`ifdef MULSEQ_SIGNED_EN
        // Multiplier sign bit has negative weight: subtract instead of add.
        if (last_step && q_lsb) begin
          fn = FN_SUBR;
          C0 = 1'b1;
        end
`endif
      end
      S_RDLO: begin
        // Y <- 0 OR Q : low product half
        dst     = DST_NOP;
        fn      = FN_OR;
        src     = SRC_ZQ;
        y_valid = 1'b1;
      end
      S_RDHI: begin
        // Y <- 0 OR B (accumulator) : high product half
        dst     = DST_NOP;
        fn      = FN_OR;
        src     = SRC_ZB;
        y_valid = 1'b1;
        y_hi    = 1'b1;
        done    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign I    = {dst, fn, src};
  assign busy = (state_reg != S_IDLE);

  // A always names the multiplicand and B the accumulator; in IDLE these
  // simply hold the last latched addresses.
  assign Aadd = mcand_reg;
  assign Badd = acc_reg;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: drives mul_seq (NBITS=8) against a behavioural 2-slice Am2901
// array with multiply link wiring. Products are computed arithmetically when
// a run starts, queued, and compared as the product halves appear on Y.
// Define MULSEQ_SIGNED_EN for both RTL and bench to exercise signed mode.
module tb_mul_seq;

  localparam int NB = 8;
`ifdef MULSEQ_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] acc_addr;
  logic [3:0] mcand_addr;
  logic       q_lsb;
  logic [8:0] i_bus;
  logic [3:0] aadd;
  logic [3:0] badd;
  logic       c0;
  logic       d_sel;
  logic [1:0] ram_msb_sel;
  logic       busy;
  logic       y_valid;
  logic       y_hi;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] sbq[$];

  mul_seq #(.NBITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .acc_addr   (acc_addr),
    .mcand_addr (mcand_addr),
    .q_lsb      (q_lsb),
    .I          (i_bus),
    .Aadd       (aadd),
    .Badd       (badd),
    .C0         (c0),
    .d_sel      (d_sel),
    .ram_msb_sel(ram_msb_sel),
    .busy       (busy),
    .y_valid    (y_valid),
    .y_hi       (y_hi),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit (2 x Am2901) array model ----------------
  logic [7:0] ram [16];
  logic [7:0] qreg;
  logic [7:0] a_op, b_op, d_val, r_op, s_op, opx, opy, f_val, y_bus;
  logic [7:0] d_bus;
  logic [8:0] sum9;
  logic       arith, c4, ovr, msb_in;
  logic       pre_en;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;

  assign q_lsb = qreg[0];

  always_comb begin
    a_op  = ram[aadd];
    b_op  = ram[badd];
    d_val = d_sel ? d_bus : 8'h00;
    r_op  = 8'h00;
    s_op  = 8'h00;
    case (i_bus[2:0])
      3'd0: begin r_op = a_op;  s_op = qreg;  end
      3'd1: begin r_op = a_op;  s_op = b_op;  end
      3'd2: begin r_op = 8'h00; s_op = qreg;  end
      3'd3: begin r_op = 8'h00; s_op = b_op;  end
      3'd4: begin r_op = 8'h00; s_op = a_op;  end
      3'd5: begin r_op = d_val; s_op = a_op;  end
      3'd6: begin r_op = d_val; s_op = qreg;  end
      default: begin r_op = d_val; s_op = 8'h00; end
    endcase
    opx   = r_op;
    opy   = s_op;
    arith = 1'b1;
    f_val = 8'h00;
    case (i_bus[5:3])
      3'd0: ;
      3'd1: opx = ~r_op;
      3'd2: opy = ~s_op;
      3'd3: begin arith = 1'b0; f_val = r_op | s_op;    end
      3'd4: begin arith = 1'b0; f_val = r_op & s_op;    end
      3'd5: begin arith = 1'b0; f_val = ~r_op & s_op;   end
      3'd6: begin arith = 1'b0; f_val = r_op ^ s_op;    end
      default: begin arith = 1'b0; f_val = ~(r_op ^ s_op); end
    endcase
    sum9 = {1'b0, opx} + {1'b0, opy} + {8'h00, c0};
    if (arith) f_val = sum9[7:0];
    c4  = arith & sum9[8];
    ovr = arith & (opx[7] == opy[7]) & (f_val[7] != opx[7]);
    case (ram_msb_sel)
      2'd0:    msb_in = 1'b0;
      2'd1:    msb_in = c4;
      default: msb_in = f_val[7] ^ ovr;
    endcase
    y_bus = (i_bus[8:6] == 3'd2) ? a_op : f_val;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      qreg <= 8'h00;
    end else begin
      if (pre_en) ram[pre_addr] <= pre_data;
      case (i_bus[8:6])
        3'd0: qreg <= f_val;
        3'd1: ;
        3'd2, 3'd3: ram[badd] <= f_val;
        3'd4: begin
          ram[badd] <= {msb_in, f_val[7:1]};
          qreg      <= {f_val[0], qreg[7:1]};
        end
        3'd5: ram[badd] <= {msb_in, f_val[7:1]};
        3'd6: begin
          ram[badd] <= {f_val[6:0], 1'b0};
          qreg      <= {qreg[6:0], 1'b0};
        end
        default: ram[badd] <= {f_val[6:0], 1'b0};
      endcase
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef MULSEQ_SIGNED_EN
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
`else
    return {8'h00, a} * {8'h00, b};
`endif
  endfunction

  task automatic preload(input logic [3:0] a, input logic [7:0] v);
    pre_addr = a;
    pre_data = v;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // One full multiply; entered and left at a negedge in IDLE.
  task automatic run_seq(input logic [3:0] acc, input logic [3:0] mc,
                         input logic [7:0] mcand, input logic [7:0] mult,
                         input int glitch_n, output int adds);
    logic [15:0] prod;
    logic [8:0]  exp_i;
    logic [8:0]  e;
    logic        exp_c0, sub, q, got_done;
    int          n, steps;
    prod = exp_prod(mcand, mult);
    sbq.push_back({1'b0, prod[7:0]});
    sbq.push_back({1'b1, prod[15:8]});
    acc_addr = acc; mcand_addr = mc; d_bus = mult; start = 1'b1;
    n = 0; adds = 0; steps = 0; got_done = 1'b0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      start      = (n == glitch_n);
      acc_addr   = ~acc;
      mcand_addr = ~mc;
      exp_c0 = 1'b0;
      q      = qreg[0];
      if (n == 1) exp_i = 9'b000_000_111;
      else if (n == 2) exp_i = 9'b011_100_011;
      else if (n <= NB + 2) begin
        sub    = SIGNED_MODE && (n == NB + 2) && q;
        exp_i  = {3'b100, sub ? 3'b001 : 3'b000, q ? 3'b001 : 3'b011};
        exp_c0 = sub;
        steps++;
        if (q) adds++;
        n_vec++;
        if (ram_msb_sel !== (SIGNED_MODE ? 2'd2 : 2'd1)) begin
          n_err++; $display("FAIL ram_msb_sel n=%0d: got %0d, expected %0d", n, ram_msb_sel, SIGNED_MODE ? 2 : 1);
        end
        n_vec++;
        if (aadd !== mc) begin
          n_err++; $display("FAIL step_aadd n=%0d: got %0h, expected %0h", n, aadd, mc);
        end
      end else if (n == NB + 3) exp_i = 9'b001_011_010;
      else exp_i = 9'b001_011_011;
      n_vec++;
      if (i_bus !== exp_i) begin
        n_err++; $display("FAIL instr n=%0d: got %b, expected %b", n, i_bus, exp_i);
      end
      if (n <= NB + 2) begin
        n_vec++;
        if (c0 !== exp_c0) begin
          n_err++; $display("FAIL c0 n=%0d: got %b, expected %b", n, c0, exp_c0);
        end
      end
      n_vec++;
      if (d_sel !== (n == 1)) begin
        n_err++; $display("FAIL d_sel n=%0d: got %b, expected %b", n, d_sel, n == 1);
      end
      n_vec++;
      if ({busy, done, y_valid} !== {1'b1, n == NB + 4, n >= NB + 3}) begin
        n_err++; $display("FAIL flags n=%0d: got busy/done/y_valid=%b, expected %b", n,
                          {busy, done, y_valid}, {1'b1, n == NB + 4, n >= NB + 3});
      end
      n_vec++;
      if (badd !== acc) begin
        n_err++; $display("FAIL badd n=%0d: got %0h, expected %0h", n, badd, acc);
      end
      if (y_valid === 1'b1) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++; $display("FAIL y_unexpected n=%0d: got %0h, expected no output", n, y_bus);
        end else begin
          e = sbq.pop_front();
          if ({y_hi, y_bus} !== e) begin
            n_err++; $display("FAIL y_product n=%0d: got hi=%b y=%h, expected hi=%b y=%h",
                              n, y_hi, y_bus, e[8], e[7:0]);
          end
        end
      end
      got_done = (done === 1'b1);
    end
    n_vec++;
    if (n !== NB + 4) begin
      n_err++; $display("FAIL done_latency: got %0d, expected %0d", n, NB + 4);
    end
    n_vec++;
    if (steps !== NB) begin
      n_err++; $display("FAIL step_count: got %0d, expected %0d", steps, NB);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done, y_valid} !== 3'b000) begin
      n_err++; $display("FAIL idle_flags: got %b, expected 000", {busy, done, y_valid});
    end
    n_vec++;
    if ({aadd, badd} !== {mc, acc}) begin
      n_err++; $display("FAIL idle_hold_addr: got %h, expected %h", {aadd, badd}, {mc, acc});
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
    $display("mul %h x %h -> expected %h, done at cycle %0d", mcand, mult, prod, n);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; acc_addr = 4'hA; mcand_addr = 4'h6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (i_bus !== 9'b001_011_011) begin
        n_err++; $display("FAIL reset_instr: got %b, expected 001011011", i_bus);
      end
      n_vec++;
      if ({busy, done, y_valid, y_hi} !== 4'b0000) begin
        n_err++; $display("FAIL reset_flags: got %b, expected 0000", {busy, done, y_valid, y_hi});
      end
      n_vec++;
      if ({aadd, badd} !== 8'h00) begin
        n_err++; $display("FAIL reset_addr: got %h, expected 00", {aadd, badd});
      end
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, aadd, badd} !== 9'h000) begin
      n_err++; $display("FAIL reset_start_ignored: got %h, expected 000", {busy, aadd, badd});
    end
    $display("reset check complete");
  endtask

  task automatic test_basic();
    int adds;
    preload(4'd3, 8'hA5);
    preload(4'd5, 8'd13);
    run_seq(4'd3, 4'd5, 8'd13, 8'd11, 0, adds);
  endtask

  task automatic test_max();
    int adds;
    preload(4'd5, 8'hFF);
    run_seq(4'd3, 4'd5, 8'hFF, 8'hFF, 0, adds);
    n_vec++;
    if (adds !== NB) begin
      n_err++; $display("FAIL add_steps: got %0d, expected %0d", adds, NB);
    end
  endtask

  task automatic test_back_to_back();
    int adds;
    preload(4'd7, 8'd100);
    preload(4'd9, 8'd200);
    run_seq(4'd2, 4'd7, 8'd100, 8'd37, 5, adds);
    run_seq(4'd4, 4'd9, 8'd200, 8'd3, 0, adds);
  endtask

  task automatic test_reset_mid();
    int adds;
    preload(4'd5, 8'd77);
    acc_addr = 4'd3; mcand_addr = 4'd5; d_bus = 8'd99; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_vec++;
    if (i_bus[8:6] !== 3'b100) begin
      n_err++; $display("FAIL mid_in_step: got dest %b, expected 100", i_bus[8:6]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({busy, done, y_valid, y_hi} !== 4'b0000) begin
      n_err++; $display("FAIL mid_reset_flags: got %b, expected 0000", {busy, done, y_valid, y_hi});
    end
    n_vec++;
    if (i_bus !== 9'b001_011_011) begin
      n_err++; $display("FAIL mid_reset_instr: got %b, expected 001011011", i_bus);
    end
    n_vec++;
    if ({aadd, badd} !== 8'h00) begin
      n_err++; $display("FAIL mid_reset_addr: got %h, expected 00", {aadd, badd});
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, y_valid} !== 3'b000) begin
        n_err++; $display("FAIL mid_reset_quiet c=%0d: got %b, expected 000", c, {busy, done, y_valid});
      end
    end
    $display("reset during step 4 complete");
    preload(4'd1, 8'd6);
    run_seq(4'd0, 4'd1, 8'd6, 8'd7, 0, adds);
  endtask

`ifdef MULSEQ_SIGNED_EN
  task automatic test_signed();
    int adds;
    preload(4'd5, 8'hFD);
    run_seq(4'd3, 4'd5, 8'hFD, 8'd5, 0, adds);
    preload(4'd5, 8'd5);
    run_seq(4'd3, 4'd5, 8'd5, 8'hFD, 0, adds);
    preload(4'd5, 8'h80);
    run_seq(4'd3, 4'd5, 8'h80, 8'h80, 0, adds);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; acc_addr = 4'd0; mcand_addr = 4'd0;
    d_bus = 8'h00; pre_en = 1'b0; pre_addr = 4'd0; pre_data = 8'h00;
    test_reset();
    test_basic();
    test_reset();
    test_max();
    test_back_to_back();
    test_reset_mid();
`ifdef MULSEQ_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
